// File: rtl/ipa_sched_pkg.sv
// rtl/ipa_sched_pkg.sv - shared types and helpers for the IPA context-launch scheduler
// Purpose: state encoding, default config-ID width and timeout counter sizing
//          used by ipa_ctx_sched and its arbiter.
// Ports:   none (package).
package ipa_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LAUNCH = 3'd1,
      ST_LOAD   = 3'd2,
      ST_EXEC   = 3'd3,
      ST_DONE   = 3'd4
   } sched_state_t;

   localparam int IPA_ID_WIDTH = 5;

   // The load counter only has to reach timeout-1, so clog2 of the timeout is enough.
   function automatic int tmo_cnt_width(input int timeout);
      return (timeout > 1) ? $clog2(timeout) : 1;
   endfunction

endpackage

// File: rtl/ipa_rr_arbiter.sv
// rtl/ipa_rr_arbiter.sv - combinational round-robin arbiter
// Purpose: picks the first active request starting at ptr and walking upward
//          cyclically; ptr is the highest-priority index.
// Ports:   req    - request vector
//          ptr    - current highest-priority index (register lives in the parent)
//          en     - arbitration enable; gnt is all zero when low
//          gnt    - one-hot grant
//          winner - index of the granted request (0 when nothing is granted)
module ipa_rr_arbiter
   import ipa_sched_pkg::*;
#(
   parameter int  NB_REQ = 4,
   localparam int IDX_W  = $clog2(NB_REQ)
) (
   input  logic [NB_REQ-1:0] req,
   input  logic [IDX_W-1:0]  ptr,
   input  logic              en,
   output logic [NB_REQ-1:0] gnt,
   output logic [IDX_W-1:0]  winner
);

   logic             found;
   logic [IDX_W-1:0] idx;

   always_comb begin
      gnt    = '0;
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int i = 0; i < NB_REQ; i++) begin
         idx = IDX_W'((int'(ptr) + i) % NB_REQ);
         if (en && !found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            winner   = idx;
         end
      end
   end

endmodule

// File: rtl/ipa_ctx_sched.sv
// rtl/ipa_ctx_sched.sv - context-launch scheduler in front of the IPA context DMA
// Purpose: arbitrates kernel launch requests, starts one context load at a time,
//          tracks it through load and execution and reports completion (or load
//          timeout) to the owning requester.
// Ports:   Clk, Reset            - clock, asynchronous active-low reset
//          req_i/req_id_i/req_addr_i - per-requester launch request, config ID, base address
//          gnt_o                 - one-hot grant pulse
//          done_o/done_id_o/err_o - one-hot completion pulse, its ID, timeout flag
//          fetch_en_o/fetch_id_o/fetch_addr_o - context fetch command to the DMA
//          dma_exec_en_i         - DMA reports the context loaded
//          exec_comp_i           - array reports execution complete
//          busy_o/owner_o        - scheduler busy, index of the current owner
module ipa_ctx_sched
   import ipa_sched_pkg::*;
#(
   parameter int  NB_REQ         = 4,
   parameter int  GCM_ADDR_WIDTH = 9,
   parameter int  ID_WIDTH       = IPA_ID_WIDTH,
   parameter int  LOAD_TIMEOUT   = 1024,
   localparam int IDX_W          = $clog2(NB_REQ),
   localparam int CNT_W          = tmo_cnt_width(LOAD_TIMEOUT)
) (
   input  logic                             Clk,
   input  logic                             Reset,
   input  logic [NB_REQ-1:0]                req_i,
   input  logic [NB_REQ*ID_WIDTH-1:0]       req_id_i,
   input  logic [NB_REQ*GCM_ADDR_WIDTH-1:0] req_addr_i,
   output logic [NB_REQ-1:0]                gnt_o,
   output logic [NB_REQ-1:0]                done_o,
   output logic [ID_WIDTH-1:0]              done_id_o,
   output logic                             err_o,
   output logic                             fetch_en_o,
   output logic [ID_WIDTH-1:0]              fetch_id_o,
   output logic [GCM_ADDR_WIDTH-1:0]        fetch_addr_o,
   input  logic                             dma_exec_en_i,
   input  logic                             exec_comp_i,
   output logic                             busy_o,
   output logic [IDX_W-1:0]                 owner_o
);

   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOAD_TIMEOUT - 1);

   sched_state_t            state_q, state_d;
   logic [IDX_W-1:0]        ptr_q, owner_q, winner;
   logic [CNT_W-1:0]        cnt_q;
   logic                    err_q;
   logic [ID_WIDTH-1:0]     id_q;
   logic [GCM_ADDR_WIDTH-1:0] addr_q;
   logic [NB_REQ-1:0]       arb_gnt;
   logic                    arb_en, take, tmo_hit;

   // Grant is the only output that follows an input combinationally; it is
   // held off while Reset is asserted so every output reads zero in reset.
   assign arb_en  = (state_q == ST_IDLE) && Reset;
   assign take    = |arb_gnt;
   assign tmo_hit = (cnt_q == TMO_LAST);

   ipa_rr_arbiter #(.NB_REQ(NB_REQ)) u_arb (
      .req    (req_i),
      .ptr    (ptr_q),
      .en     (arb_en),
      .gnt    (arb_gnt),
      .winner (winner)
   );

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      gnt_o      = arb_gnt;
      busy_o     = (state_q != ST_IDLE);
      fetch_en_o = 1'b0;
      done_o     = '0;
      done_id_o  = '0;
      err_o      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (take) state_d = ST_LAUNCH;
         end
         ST_LAUNCH: begin
            fetch_en_o = 1'b1;
            state_d    = ST_LOAD;
         end
         ST_LOAD: begin
            // Exec-enable takes priority over a timeout landing in the same cycle.
            if (dma_exec_en_i)  state_d = exec_comp_i ? ST_DONE : ST_EXEC;
            else if (tmo_hit)   state_d = ST_DONE;
         end
         ST_EXEC: begin
            if (exec_comp_i) state_d = ST_DONE;
         end
         ST_DONE: begin
            done_o    = NB_REQ'(1) << owner_q;
            done_id_o = id_q;
            err_o     = err_q;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         ptr_q   <= '0;
         owner_q <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         id_q    <= '0;
         addr_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (take) begin
                  owner_q <= winner;
                  id_q    <= req_id_i[winner*ID_WIDTH +: ID_WIDTH];
                  addr_q  <= req_addr_i[winner*GCM_ADDR_WIDTH +: GCM_ADDR_WIDTH];
               end
            end
            ST_LAUNCH: begin
               cnt_q <= '0;
               err_q <= 1'b0;
            end
            ST_LOAD: begin
               cnt_q <= cnt_q + 1'b1;
               if (!dma_exec_en_i && tmo_hit) err_q <= 1'b1;
            end
            ST_DONE: begin
               ptr_q <= (owner_q == IDX_W'(NB_REQ - 1)) ? '0 : owner_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign fetch_id_o   = id_q;
   assign fetch_addr_o = addr_q;
   assign owner_o      = owner_q;

endmodule
